gsensor_spi_reader: RTL

//  SPI master sequencer for the board accelerometer (4-wire SPI, mode 3: SCLK idles high).

---
 rtl/gsensor_spi_reader.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/gsensor_spi_reader.sv
// gsensor_spi_reader: SPI mode-3 master for the board accelerometer.
// Identifies the part (WHO_AM_I), writes CTRL_REG1, then reads OUT_X_L/OUT_X_H
// on every INT1 rising edge or poll timeout and publishes the sample with a
// one-cycle DATA_RDY strobe. Debug state is exported for the probe stage.
module gsensor_spi_reader #(
  parameter int unsigned CLK_DIV     = 25,
  parameter int unsigned POLL_CYCLES = 500000,
  parameter logic [7:0]  CTRL1_VAL   = 8'h57,
  parameter logic [7:0]  ID_EXPECT   = 8'h33
) (
  input  logic        SYS_CLK,
  input  logic        RESET_N,
  input  logic        INT1,
  input  logic        DO,
  output logic        CS,
  output logic        SCLK,
  output logic        DIN,
  output logic [15:0] OUT_X,
  output logic [7:0]  OUT_X_L,
  output logic [7:0]  OUT_X_H,
  output logic [7:0]  WHO_AM_I,
  output logic        ID_OK,
  output logic        DATA_RDY,
  output logic [7:0]  ST,
  output logic [7:0]  BIT_CNT,
  output logic [7:0]  WORD_CNT,
  output logic [15:0] RDATA
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WHO  = 3'd1,
    S_CFG  = 3'd2,
    S_WAIT = 3'd3,
    S_RD   = 3'd4,
    S_DONE = 3'd5,
    S_GAP  = 3'd6
  } state_t;

  localparam logic [31:0] DIV_LAST  = 32'(CLK_DIV - 1);
  localparam logic [31:0] GAP_LAST  = 32'(2 * CLK_DIV - 1);
  localparam logic [31:0] POLL_LAST = 32'(POLL_CYCLES - 1);

  localparam logic [7:0] ADDR_WHO = 8'h8F;  // read 0x0F
  localparam logic [7:0] ADDR_CFG = 8'h20;  // write CTRL_REG1
  localparam logic [7:0] ADDR_RD  = 8'hE8;  // read, auto-increment, from 0x28

  // A frame is split into half-periods of CLK_DIV cycles: half 0 is the lead-in
  // after CS falls, odd halves are SCLK low, even halves SCLK high, and the
  // final half is the tail before CS rises. last_half = 16*bytes + 1.
  localparam logic [5:0] LAST_HALF_2B = 6'd33;
  localparam logic [5:0] LAST_HALF_3B = 6'd49;

  state_t      state;
  state_t      gap_next;
  logic [31:0] div_cnt;
  logic [5:0]  half_cnt;
  logic [5:0]  last_half;
  logic [23:0] tx_sr;
  logic [31:0] gap_cnt;
  logic [31:0] timer;
  logic [2:0]  int_sync;
  logic        pending;

  logic        int_rise;
  logic        half_tick;
  logic        frame_end;
  logic        launch;
  state_t      launch_st;
  logic [23:0] launch_word;
  logic [5:0]  launch_last;

  assign int_rise  = int_sync[1] & ~int_sync[2];
  assign half_tick = (div_cnt == DIV_LAST);
  assign frame_end = half_tick && (half_cnt == last_half);
  assign ST        = {5'd0, state};

  // Decide whether a new frame starts on the next edge and what it sends.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    launch      = 1'b0;
    launch_st   = S_WHO;
    launch_word = {ADDR_WHO, 16'h0000};
    launch_last = LAST_HALF_2B;
    case (state)
      S_IDLE: begin
        launch    = 1'b1;
        launch_st = S_WHO;
      end
      S_GAP: begin
        if (gap_cnt == GAP_LAST && gap_next != S_WAIT) begin
          launch    = 1'b1;
          launch_st = gap_next;
        end
      end
      S_WAIT: begin
        if (pending || timer == POLL_LAST) begin
          launch    = 1'b1;
          launch_st = S_RD;
        end
      end
      default: ;
    endcase
    case (launch_st)
      S_CFG: begin
        launch_word = {ADDR_CFG, CTRL1_VAL, 8'h00};
        launch_last = LAST_HALF_2B;
      end
      S_RD: begin
        launch_word = {ADDR_RD, 16'h0000};
        launch_last = LAST_HALF_3B;
      end
      default: begin
        launch_word = {ADDR_WHO, 16'h0000};
        launch_last = LAST_HALF_2B;
      end
    endcase
  end

  // Sequencer: state, SPI pin generation, shift/counter debug state and results.
  always_ff @(posedge SYS_CLK) begin
    if (!RESET_N) begin
      // NOTE: all state is plain flops (no memories), so everything is reset; an abort leaves nothing stale.
      state     <= S_IDLE;
      gap_next  <= S_WAIT;
      div_cnt   <= '0;
      half_cnt  <= '0;
      last_half <= LAST_HALF_2B;
      tx_sr     <= '0;
      gap_cnt   <= '0;
      timer     <= '0;
      int_sync  <= '0;
      pending   <= 1'b0;
      CS        <= 1'b1;
      SCLK      <= 1'b1;
      DIN       <= 1'b0;
      OUT_X     <= '0;
      OUT_X_L   <= '0;
      OUT_X_H   <= '0;
      WHO_AM_I  <= '0;
      ID_OK     <= 1'b0;
      DATA_RDY  <= 1'b0;
      BIT_CNT   <= '0;
      WORD_CNT  <= '0;
      RDATA     <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments; a later assignment in this block overrides an earlier default.
      DATA_RDY <= 1'b0;
      int_sync <= {int_sync[1:0], INT1};

      // An edge arriving on the RD entry edge survives the clear below.
      if (launch && launch_st == S_RD) pending <= 1'b0;
      if (int_rise)                    pending <= 1'b1;

      case (state)
        S_WHO, S_CFG, S_RD: begin
          if (half_tick) begin
            div_cnt  <= '0;
            half_cnt <= half_cnt + 6'd1;
            if (frame_end) begin
              CS      <= 1'b1;
              DIN     <= 1'b0;
              gap_cnt <= '0;
              case (state)
                S_WHO: begin
                  WHO_AM_I <= RDATA[7:0];
                  ID_OK    <= (RDATA[7:0] == ID_EXPECT);
                  gap_next <= (RDATA[7:0] == ID_EXPECT) ? S_CFG : S_WHO;
                  state    <= S_GAP;
                end
                S_CFG: begin
                  gap_next <= S_WAIT;
                  state    <= S_GAP;
                end
                default: begin
                  OUT_X_L  <= RDATA[15:8];
                  OUT_X_H  <= RDATA[7:0];
                  OUT_X    <= {RDATA[7:0], RDATA[15:8]};
                  DATA_RDY <= 1'b1;
                  state    <= S_DONE;
                end
              endcase
            end else if (half_cnt + 6'd1 < last_half) begin
              if (!half_cnt[0]) begin
                // Entering a low half: falling edge, present next MOSI bit.
                SCLK  <= 1'b0;
                DIN   <= tx_sr[23];
                tx_sr <= {tx_sr[22:0], 1'b0};
              end else begin
                // Entering a high half: rising edge, sample MISO.
                SCLK  <= 1'b1;
                RDATA <= {RDATA[14:0], DO};
                if (BIT_CNT == 8'd7) begin
                  BIT_CNT  <= '0;
                  WORD_CNT <= WORD_CNT + 8'd1;
                end else begin
                  BIT_CNT <= BIT_CNT + 8'd1;
                end
              end
            end
          end else begin
            div_cnt <= div_cnt + 32'd1;
          end
        end
        S_DONE: begin
          gap_next <= S_WAIT;
          gap_cnt  <= '0;
          state    <= S_GAP;
        end
        S_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            if (gap_next == S_WAIT) state <= S_WAIT;
          end else begin
            gap_cnt <= gap_cnt + 32'd1;
          end
        end
        S_WAIT: begin
          if (!launch) timer <= timer + 32'd1;
        end
        S_IDLE: ;
        default: state <= S_IDLE;
      endcase

      if (launch) begin
        state     <= launch_st;
        CS        <= 1'b0;
        SCLK      <= 1'b1;
        DIN       <= 1'b0;
        div_cnt   <= '0;
        half_cnt  <= '0;
        last_half <= launch_last;
        tx_sr     <= launch_word;
        BIT_CNT   <= '0;
        WORD_CNT  <= '0;
        RDATA     <= '0;
        timer     <= '0;
        gap_cnt   <= '0;
      end
    end
  end

endmodule
